// File: rtl/sonar_varredura.sv
// Sweep scheduler: ping-pongs the servo over N_POS positions, settles at each one,
// then fires one measurement cycle on the sonar control unit and waits for it (with timeout).
module sonar_varredura #(
  parameter int N_POS      = 8,
  parameter int W_POS      = 3,
  parameter int T_ASSENTAR = 25000000,
  parameter int T_TIMEOUT  = 50000000,
  parameter int W_CNT      = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             medida_pronto,
  output logic [W_POS-1:0] posicao,
  output logic             sentido,
  output logic             iniciar_medida,
  output logic             fim_varredura,
  output logic             erro_timeout,
  output logic [3:0]       db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    POSICIONA = 4'd1,
    ASSENTA   = 4'd2,
    MEDE      = 4'd3,
    AGUARDA   = 4'd4,
    PROXIMA   = 4'd5
  } estado_t;

  localparam logic [W_CNT-1:0] ULT_ASSENTAR = W_CNT'(T_ASSENTAR - 1);
  localparam logic [W_CNT-1:0] ULT_TIMEOUT  = W_CNT'(T_TIMEOUT - 1);
  localparam logic [W_POS-1:0] POS_MAX      = W_POS'(N_POS - 1);

  estado_t          estado, proximo;
  logic [W_CNT-1:0] contador;
  logic             assentou, expirou;

  assign assentou = (contador == ULT_ASSENTAR);
  assign expirou  = (contador == ULT_TIMEOUT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Dropping ligar overrides every transition and returns to idle.
  always_comb begin
    proximo = estado;
    if (!ligar) begin
      proximo = INICIAL;
    end else begin
      case (estado)
        INICIAL:   proximo = POSICIONA;
        POSICIONA: proximo = ASSENTA;
        ASSENTA:   if (assentou) proximo = MEDE;
        MEDE:      proximo = AGUARDA;
        AGUARDA:   if (medida_pronto || expirou) proximo = PROXIMA;
        PROXIMA:   proximo = POSICIONA;
        default:   proximo = INICIAL;
      endcase
    end
  end

  always_comb begin
    iniciar_medida = (estado == MEDE);
    case (estado)
      INICIAL:   db_estado = 4'd0;
      POSICIONA: db_estado = 4'd1;
      ASSENTA:   db_estado = 4'd2;
      MEDE:      db_estado = 4'd3;
      AGUARDA:   db_estado = 4'd4;
      PROXIMA:   db_estado = 4'd5;
      default:   db_estado = 4'hE;
    endcase
  end

  // Shared counter, servo position and the registered one-cycle pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador      <= '0;
      posicao       <= '0;
      sentido       <= 1'b0;
      fim_varredura <= 1'b0;
      erro_timeout  <= 1'b0;
    end else begin
      fim_varredura <= 1'b0;
      erro_timeout  <= 1'b0;
      if (!ligar) begin
        contador <= '0;
        posicao  <= '0;
        sentido  <= 1'b0;
      end else begin
        case (estado)
          ASSENTA: begin
            if (assentou) contador <= '0;
            else          contador <= contador + 1'b1;
          end
          AGUARDA: begin
            if (medida_pronto || expirou) begin
              contador     <= '0;
              erro_timeout <= !medida_pronto;
            end else begin
              contador <= contador + 1'b1;
            end
          end
          PROXIMA: begin
            contador <= '0;
            if (!sentido) begin
              if (posicao == POS_MAX) begin
                posicao       <= POS_MAX - 1'b1;
                sentido       <= 1'b1;
                fim_varredura <= 1'b1;
              end else begin
                posicao <= posicao + 1'b1;
              end
            end else begin
              if (posicao == '0) begin
                posicao       <= W_POS'(1);
                sentido       <= 1'b0;
                fim_varredura <= 1'b1;
              end else begin
                posicao <= posicao - 1'b1;
              end
            end
          end
          default: contador <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sonar_varredura.sv
// Bench for sonar_varredura: a phase/duration model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sonar_varredura;

  localparam int N_POS      = 4;
  localparam int W_POS      = 2;
  localparam int T_ASSENTAR = 3;
  localparam int T_TIMEOUT  = 10;
  localparam int W_CNT      = 4;

  localparam int IDLE = 0, POSI = 1, SETTLE = 2, MEAS = 3, WAITM = 4, NEXT = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ligar = 1'b0;
  logic             medida_pronto = 1'b0;
  logic [W_POS-1:0] posicao;
  logic             sentido;
  logic             iniciar_medida;
  logic             fim_varredura;
  logic             erro_timeout;
  logic [3:0]       db_estado;

  int vectors = 0;
  int miscompares = 0;
  int fim_seen = 0;

  int m_fase = IDLE;
  int m_t    = 0;
  int m_pos  = 0;
  int m_dir  = 1;
  int m_fim  = 0;
  int m_erro = 0;

  sonar_varredura #(
    .N_POS(N_POS), .W_POS(W_POS), .T_ASSENTAR(T_ASSENTAR),
    .T_TIMEOUT(T_TIMEOUT), .W_CNT(W_CNT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ligar(ligar),
    .medida_pronto(medida_pronto),
    .posicao(posicao),
    .sentido(sentido),
    .iniciar_medida(iniciar_medida),
    .fim_varredura(fim_varredura),
    .erro_timeout(erro_timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Model: phase plus cycles spent in it; position moves by a signed step that bounces at the ends.
  always @(posedge clock or negedge reset) begin
    if (!reset || !ligar) begin
      m_fase <= IDLE; m_t <= 0; m_pos <= 0; m_dir <= 1; m_fim <= 0; m_erro <= 0;
    end else begin
      m_fim  <= 0;
      m_erro <= 0;
      case (m_fase)
        IDLE: m_fase <= POSI;
        POSI: begin m_fase <= SETTLE; m_t <= 0; end
        SETTLE: begin
          m_t <= m_t + 1;
          if (m_t + 1 == T_ASSENTAR) m_fase <= MEAS;
        end
        MEAS: begin m_fase <= WAITM; m_t <= 0; end
        WAITM: begin
          m_t <= m_t + 1;
          if (medida_pronto) m_fase <= NEXT;
          else if (m_t + 1 == T_TIMEOUT) begin m_fase <= NEXT; m_erro <= 1; end
        end
        NEXT: begin
          if (m_pos + m_dir < 0 || m_pos + m_dir > N_POS - 1) begin
            m_dir <= -m_dir;
            m_pos <= m_pos - m_dir;
            m_fim <= 1;
          end else begin
            m_pos <= m_pos + m_dir;
          end
          m_fase <= POSI;
        end
        default: m_fase <= IDLE;
      endcase
    end
  end

  task automatic compareCycle();
    int e_ini, e_sent;
    e_ini  = (m_fase == MEAS) ? 1 : 0;
    e_sent = (m_dir < 0) ? 1 : 0;
    vectors++;
    if (int'(db_estado) != m_fase || int'(posicao) != m_pos || int'(sentido) != e_sent ||
        int'(iniciar_medida) != e_ini || int'(fim_varredura) != m_fim || int'(erro_timeout) != m_erro) begin
      miscompares++;
      $display("[TB] FAIL cycle_model t=%0t got est=%0d pos=%0d sent=%0d ini=%0d fim=%0d erro=%0d want est=%0d pos=%0d sent=%0d ini=%0d fim=%0d erro=%0d",
               $time, db_estado, posicao, sentido, iniciar_medida, fim_varredura, erro_timeout,
               m_fase, m_pos, e_sent, e_ini, m_fim, m_erro);
    end
    if (fim_varredura) fim_seen++;
  endtask

  // One clock cycle: compare on the falling edge, then return 2 time units after the rising edge.
  task automatic applyStimulus();
    @(negedge clock);
    compareCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string name, input int est, input int pos, input int sent,
                             input int ini, input int fim, input int erro);
    vectors++;
    if (int'(db_estado) != est || int'(posicao) != pos || int'(sentido) != sent ||
        int'(iniciar_medida) != ini || int'(fim_varredura) != fim || int'(erro_timeout) != erro) begin
      miscompares++;
      $display("[TB] FAIL %s got est=%0d pos=%0d sent=%0d ini=%0d fim=%0d erro=%0d want est=%0d pos=%0d sent=%0d ini=%0d fim=%0d erro=%0d",
               name, db_estado, posicao, sentido, iniciar_medida, fim_varredura, erro_timeout,
               est, pos, sent, ini, fim, erro);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic waitIniciar(input string name);
    int n;
    n = 0;
    while (!iniciar_medida && n < 40) begin
      applyStimulus();
      n++;
    end
    vectors++;
    if (!iniciar_medida) begin
      miscompares++;
      $display("[TB] FAIL %s got no iniciar_medida want pulse within 40 cycles", name);
    end
  endtask

  task automatic measure(input string name);
    waitIniciar(name);
    repeat (2) applyStimulus();
    medida_pronto = 1'b1;
    applyStimulus();
    medida_pronto = 1'b0;
  endtask

  initial begin
    int exp_est[5]  = '{1, 2, 2, 2, 3};
    int exp_ini[5]  = '{0, 0, 0, 0, 1};
    int exp_pos[8]  = '{0, 1, 2, 3, 2, 1, 0, 1};
    int exp_sent[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    int fim_base;
    int n;

    repeat (2) applyStimulus();
    checkOutput("reset_state", 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    ligar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("startup_%0d", i), exp_est[i], 0, 0, exp_ini[i], 0, 0);
    end

    fim_base = fim_seen;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) waitIniciar($sformatf("sweep_wait_%0d", i));
      checkValue($sformatf("sweep_pos_%0d", i), int'(posicao), exp_pos[i]);
      checkValue($sformatf("sweep_sent_%0d", i), int'(sentido), exp_sent[i]);
      repeat (2) applyStimulus();
      medida_pronto = 1'b1;
      applyStimulus();
      medida_pronto = 1'b0;
    end
    applyStimulus();
    checkValue("sweep_fim_count", fim_seen - fim_base, 2);

    ligar = 1'b0;
    applyStimulus();
    ligar = 1'b1;

    waitIniciar("timeout_wait");
    checkValue("timeout_pos", int'(posicao), 0);
    applyStimulus();
    n = 0;
    while (db_estado == 4'd4 && n < 20) begin
      n++;
      applyStimulus();
    end
    checkValue("timeout_len", n, 10);
    checkOutput("timeout_pulse", 5, 0, 0, 0, 0, 1);
    applyStimulus();
    checkOutput("timeout_after", 1, 1, 0, 0, 0, 0);

    waitIniciar("late_wait");
    applyStimulus();
    repeat (9) applyStimulus();
    medida_pronto = 1'b1;
    applyStimulus();
    medida_pronto = 1'b0;
    checkOutput("late_success", 5, 1, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("late_next", 1, 2, 0, 0, 0, 0);

    measure("to_top");
    measure("at_top");
    applyStimulus();
    checkOutput("bounce_top", 1, 2, 1, 0, 1, 0);

    waitIniciar("drop_wait");
    repeat (2) applyStimulus();
    ligar = 1'b0;
    applyStimulus();
    checkOutput("ligar_off", 0, 0, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("ligar_off_hold", 0, 0, 0, 0, 0, 0);
    ligar = 1'b1;
    applyStimulus();
    checkOutput("restart", 1, 0, 0, 0, 0, 0);

    applyStimulus();
    medida_pronto = 1'b1;
    applyStimulus();
    medida_pronto = 1'b0;
    checkOutput("stray_in_assenta", 2, 0, 0, 0, 0, 0);

    reset = 1'b0;
    #1;
    checkOutput("reset_async", 0, 0, 0, 0, 0, 0);
    ligar = 1'b0;
    repeat (2) applyStimulus();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      medida_pronto = 1'b1;
      applyStimulus();
      medida_pronto = 1'b0;
      applyStimulus();
      checkOutput($sformatf("idle_stray_%0d", i), 0, 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
